// File: rtl/savestate_sched_if.sv
// Handshake bundle between the savestate scheduler and its UI, rewind logic,
// emulated core and savestate engine.
interface savestate_sched_if;
  logic       allow_ss;
  logic       ui_save;
  logic       ui_load;
  logic [1:0] ui_slot;
  logic       rewind_enable;
  logic       rewind_req;
  logic       core_pause_req;
  logic       core_paused;
  logic       eng_start;
  logic       eng_load;
  logic [2:0] eng_slot;
  logic       eng_done;
  logic       eng_error;
  logic       busy;
  logic       info_req;
  logic [7:0] info_code;
  logic [2:0] rewind_depth;

  modport slave (
    input  allow_ss, ui_save, ui_load, ui_slot, rewind_enable, rewind_req,
    input  core_paused, eng_done, eng_error,
    output core_pause_req, eng_start, eng_load, eng_slot,
    output busy, info_req, info_code, rewind_depth
  );

  modport master (
    output allow_ss, ui_save, ui_load, ui_slot, rewind_enable, rewind_req,
    output core_paused, eng_done, eng_error,
    input  core_pause_req, eng_start, eng_load, eng_slot,
    input  busy, info_req, info_code, rewind_depth
  );
endinterface

// File: rtl/savestate_sched.sv
// Savestate scheduler: arbitrates user, rewind-capture and rewind-load requests,
// pauses the core around each engine operation and tracks a 4-entry rewind ring.
module savestate_sched #(
  parameter int TIMEOUT_BITS       = 24,
  parameter int REWIND_PERIOD_BITS = 22
) (
  input  logic             clk,
  input  logic             reset_n,
  savestate_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE,
    S_START,
    S_WAIT,
    S_RESUME
  } state_t;

  typedef enum logic [1:0] {
    OP_USER,
    OP_CAP,
    OP_RWD
  } op_t;

  localparam logic [7:0] INFO_USER_BASE = 8'd6;
  localparam logic [7:0] INFO_ERROR     = 8'd12;
  localparam logic [7:0] INFO_TIMEOUT   = 8'd13;
  localparam logic [7:0] INFO_RWD_LOAD  = 8'd14;
  localparam logic [7:0] INFO_RWD_EMPTY = 8'd15;

  state_t                        r_state;
  op_t                           r_op;
  logic                          r_upend;
  logic                          r_cpend;
  logic                          r_rpend;
  logic [1:0]                    r_uslot;
  logic                          r_uload;
  logic [1:0]                    r_op_uslot;
  logic                          r_op_uload;
  logic [REWIND_PERIOD_BITS-1:0] r_cap_cnt;
  logic [TIMEOUT_BITS-1:0]       r_wd;
  logic [1:0]                    r_wr_ptr;
  logic [2:0]                    r_depth;
  logic                          r_rwd_q;
  logic                          r_pause_req;
  logic                          r_eng_start;
  logic                          r_eng_load;
  logic [2:0]                    r_eng_slot;
  logic                          r_busy;
  logic                          r_info_req;
  logic [7:0]                    r_info_code;

  logic                          w_idle;
  logic                          w_ui_req;
  logic                          w_cap_en;
  logic [REWIND_PERIOD_BITS-1:0] w_cap_cnt_nxt;
  logic                          w_cap_tick;
  logic [TIMEOUT_BITS-1:0]       w_wd_nxt;
  logic                          w_wd_expire;
  logic                          w_rwd_rise;
  logic                          w_ring_clr;
  logic                          w_flags_drop;
  logic                          w_u_eff;
  logic                          w_r_eff;
  logic                          w_c_eff;
  logic [1:0]                    w_ptr_prev;
  logic [2:0]                    w_depth_inc;
  logic [7:0]                    w_user_code;

  assign w_idle        = (r_state == S_IDLE);
  assign w_ui_req      = bus.allow_ss & (bus.ui_save | bus.ui_load);
  assign w_cap_en      = bus.rewind_enable & bus.allow_ss;
  assign w_cap_cnt_nxt = r_cap_cnt + 1'b1;
  assign w_cap_tick    = w_cap_en & w_cap_cnt_nxt[REWIND_PERIOD_BITS-1];
  assign w_wd_nxt      = r_wd + 1'b1;
  assign w_wd_expire   = w_wd_nxt[TIMEOUT_BITS-1];
  assign w_rwd_rise    = bus.rewind_req & ~r_rwd_q & bus.rewind_enable;
  assign w_ring_clr    = w_idle & ~bus.rewind_enable;
  assign w_flags_drop  = w_idle & ~bus.allow_ss;

  // A rewind load is only eligible while the ring actually holds an entry.
  assign w_u_eff     = r_upend & bus.allow_ss;
  assign w_r_eff     = r_rpend & bus.allow_ss & bus.rewind_enable & (r_depth != 3'd0);
  assign w_c_eff     = r_cpend & bus.allow_ss & bus.rewind_enable;
  assign w_ptr_prev  = r_wr_ptr - 2'd1;
  assign w_depth_inc = (r_depth >= 3'd4) ? 3'd4 : r_depth + 3'd1;
  assign w_user_code = INFO_USER_BASE + {5'd0, r_op_uslot, r_op_uload};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_USER;
      r_upend     <= 1'b0;
      r_cpend     <= 1'b0;
      r_rpend     <= 1'b0;
      r_uslot     <= 2'd0;
      r_uload     <= 1'b0;
      r_op_uslot  <= 2'd0;
      r_op_uload  <= 1'b0;
      r_cap_cnt   <= '0;
      r_wd        <= '0;
      r_wr_ptr    <= 2'd0;
      r_depth     <= 3'd0;
      r_rwd_q     <= 1'b0;
      r_pause_req <= 1'b0;
      r_eng_start <= 1'b0;
      r_eng_load  <= 1'b0;
      r_eng_slot  <= 3'd0;
      r_busy      <= 1'b0;
      r_info_req  <= 1'b0;
      r_info_code <= 8'd0;
    end else begin
      r_eng_start <= 1'b0;
      r_info_req  <= 1'b0;
      r_rwd_q     <= bus.rewind_req;

      // Depth-0 warning is written first so a same-cycle result overrides it.
      if (w_rwd_rise && (r_depth == 3'd0)) begin
        r_info_req  <= 1'b1;
        r_info_code <= INFO_RWD_EMPTY;
      end

      case (r_state)
        S_IDLE: begin
          if (w_u_eff || w_r_eff || w_c_eff) begin
            r_state     <= S_PAUSE;
            r_pause_req <= 1'b1;
            r_busy      <= 1'b1;
            r_wd        <= '0;
            if (w_u_eff) begin
              r_op       <= OP_USER;
              r_op_uslot <= r_uslot;
              r_op_uload <= r_uload;
              r_upend    <= 1'b0;
            end else if (w_r_eff) begin
              r_op    <= OP_RWD;
              r_rpend <= 1'b0;
            end else begin
              r_op    <= OP_CAP;
              r_cpend <= 1'b0;
            end
          end
        end

        S_PAUSE: begin
          if (bus.core_paused) begin
            r_state     <= S_START;
            r_wd        <= '0;
            r_eng_start <= 1'b1;
            case (r_op)
              OP_USER: begin
                r_eng_load <= r_op_uload;
                r_eng_slot <= {1'b0, r_op_uslot};
              end
              OP_CAP: begin
                r_eng_load <= 1'b0;
                r_eng_slot <= {1'b1, r_wr_ptr};
              end
              default: begin
                r_eng_load <= 1'b1;
                r_eng_slot <= {1'b1, w_ptr_prev};
              end
            endcase
          end else if (w_wd_expire) begin
            r_state     <= S_RESUME;
            r_pause_req <= 1'b0;
            r_wd        <= '0;
            r_info_req  <= 1'b1;
            r_info_code <= INFO_TIMEOUT;
          end else begin
            r_wd <= w_wd_nxt;
          end
        end

        S_START: begin
          r_state <= S_WAIT;
          r_wd    <= '0;
        end

        S_WAIT: begin
          if (bus.eng_done || bus.eng_error) begin
            r_state     <= S_RESUME;
            r_pause_req <= 1'b0;
            r_wd        <= '0;
            if (bus.eng_error) begin
              r_info_req  <= 1'b1;
              r_info_code <= INFO_ERROR;
            end else begin
              case (r_op)
                OP_USER: begin
                  r_info_req  <= 1'b1;
                  r_info_code <= w_user_code;
                end
                OP_CAP: begin
                  r_wr_ptr <= r_wr_ptr + 2'd1;
                  r_depth  <= w_depth_inc;
                end
                default: begin
                  r_wr_ptr    <= w_ptr_prev;
                  r_depth     <= r_depth - 3'd1;
                  r_info_req  <= 1'b1;
                  r_info_code <= INFO_RWD_LOAD;
                end
              endcase
            end
          end else if (w_wd_expire) begin
            r_state     <= S_RESUME;
            r_pause_req <= 1'b0;
            r_wd        <= '0;
            r_info_req  <= 1'b1;
            r_info_code <= INFO_TIMEOUT;
          end else begin
            r_wd <= w_wd_nxt;
          end
        end

        S_RESUME: begin
          if (!bus.core_paused) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_eng_load <= 1'b0;
            r_eng_slot <= 3'd0;
          end
        end

        default: r_state <= S_IDLE;
      endcase

      if (w_rwd_rise && (r_depth != 3'd0)) begin
        r_rpend <= 1'b1;
      end

      if (w_flags_drop) begin
        r_upend <= 1'b0;
        r_cpend <= 1'b0;
        r_rpend <= 1'b0;
      end

      // Ring maintenance is deferred to IDLE so an in-flight capture still lands.
      if (w_ring_clr) begin
        r_cpend   <= 1'b0;
        r_rpend   <= 1'b0;
        r_cap_cnt <= '0;
        r_wr_ptr  <= 2'd0;
        r_depth   <= 3'd0;
      end else if (w_idle && (r_depth == 3'd0)) begin
        r_rpend <= 1'b0;
      end

      if (w_ui_req) begin
        r_upend <= 1'b1;
        r_uslot <= bus.ui_slot;
        r_uload <= bus.ui_load;
      end

      if (w_cap_tick) begin
        r_cap_cnt <= '0;
        r_cpend   <= 1'b1;
      end else if (w_cap_en) begin
        r_cap_cnt <= w_cap_cnt_nxt;
      end
    end
  end

  assign bus.core_pause_req = r_pause_req;
  assign bus.eng_start      = r_eng_start;
  assign bus.eng_load       = r_eng_load;
  assign bus.eng_slot       = r_eng_slot;
  assign bus.busy           = r_busy;
  assign bus.info_req       = r_info_req;
  assign bus.info_code      = r_info_code;
  assign bus.rewind_depth   = r_depth;

endmodule

// File: tb/tb_savestate_sched.sv
// Directed bench for savestate_sched: a negedge core/engine responder logs every
// engine start and info pulse; the main sequence checks them against hand values.
module tb_savestate_sched;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  savestate_sched_if bus ();

  savestate_sched #(
    .TIMEOUT_BITS       (5),
    .REWIND_PERIOD_BITS (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  int core_dly     = 3;
  int eng_dly      = 10;
  bit eng_err_mode = 1'b0;

  logic [3:0] eng_log[$];
  logic [2:0] depth_at_start[$];
  logic [7:0] info_log[$];
  logic [2:0] depth_at_info[$];

  logic [3:0] exp_cap_slot[6]  = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h4, 4'h5};
  logic [2:0] exp_cap_depth[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

  // Core and engine model, acting on the falling edge.
  initial begin
    int pcnt;
    int ecnt;
    pcnt = 0;
    ecnt = 0;
    bus.core_paused = 1'b0;
    bus.eng_done    = 1'b0;
    bus.eng_error   = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.core_pause_req && core_dly > 0) begin
        pcnt++;
        if (pcnt >= core_dly) bus.core_paused = 1'b1;
      end else begin
        pcnt = 0;
        bus.core_paused = 1'b0;
      end
      bus.eng_done  = 1'b0;
      bus.eng_error = 1'b0;
      if (ecnt > 0) begin
        ecnt--;
        if (ecnt == 0) begin
          if (eng_err_mode) bus.eng_error = 1'b1;
          else              bus.eng_done  = 1'b1;
        end
      end
      if (bus.eng_start) begin
        eng_log.push_back({bus.eng_load, bus.eng_slot});
        depth_at_start.push_back(bus.rewind_depth);
        ecnt = eng_dly;
      end
      if (bus.info_req) begin
        info_log.push_back(bus.info_code);
        depth_at_info.push_back(bus.rewind_depth);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (bus.busy !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    check({tag, " idle in budget"}, (k < budget), 1);
  endtask

  task automatic wait_eng(input string tag, input int n, input int budget);
    int k = 0;
    while (eng_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, " eng starts in budget"}, (eng_log.size() >= n), 1);
  endtask

  task automatic wait_info(input string tag, input int n, input int budget);
    int k = 0;
    while (info_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, " info in budget"}, (info_log.size() >= n), 1);
  endtask

  initial begin
    int ebase;
    int ibase;
    int n;
    int k;

    reset_n           = 1'b0;
    bus.allow_ss      = 1'b0;
    bus.ui_save       = 1'b0;
    bus.ui_load       = 1'b0;
    bus.ui_slot       = 2'd0;
    bus.rewind_enable = 1'b0;
    bus.rewind_req    = 1'b0;

    #12;
    check("reset outputs", {bus.core_pause_req, bus.eng_start, bus.eng_load, bus.eng_slot,
                            bus.busy, bus.info_req, bus.info_code, bus.rewind_depth}, 0);
    reset_n = 1'b1;
    tick();

    // User save to slot 2, slow core ack and slow engine.
    ebase = eng_log.size();
    ibase = info_log.size();
    bus.allow_ss = 1'b1;
    bus.ui_slot  = 2'd2;
    bus.ui_save  = 1'b1;
    tick();
    bus.ui_save = 1'b0;
    tick();
    check("s1 busy", bus.busy, 1);
    check("s1 pause_req", bus.core_pause_req, 1);
    wait_idle("s1", 60);
    check("s1 core_paused low at idle", bus.core_paused, 0);
    check("s1 start count", eng_log.size() - ebase, 1);
    check("s1 load/slot", eng_log[ebase], 4'h2);
    check("s1 info count", info_log.size() - ibase, 1);
    check("s1 info code", info_log[ibase], 10);
    check("s1 info_code held", bus.info_code, 10);

    // Six periodic captures with instant handshakes.
    core_dly = 1;
    eng_dly  = 1;
    ebase = eng_log.size();
    bus.rewind_enable = 1'b1;
    wait_eng("s2", ebase + 6, 200);
    wait_idle("s2", 40);
    bus.allow_ss = 1'b0;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("s2 capture %0d slot", i), eng_log[ebase + i], exp_cap_slot[i]);
      check($sformatf("s2 capture %0d depth", i), depth_at_start[ebase + i], exp_cap_depth[i]);
    end
    check("s2 depth", bus.rewind_depth, 4);

    // Two rewind loads; the second edge arrives while the first is in flight.
    ebase = eng_log.size();
    ibase = info_log.size();
    bus.allow_ss   = 1'b1;
    bus.rewind_req = 1'b1;
    tick();
    bus.rewind_req = 1'b0;
    tick(2);
    bus.rewind_req = 1'b1;
    tick();
    bus.rewind_req = 1'b0;
    wait_info("s3", ibase + 2, 60);
    bus.rewind_enable = 1'b0;
    check("s3 first load slot", eng_log[ebase], 4'hD);
    check("s3 second load slot", eng_log[ebase + 1], 4'hC);
    check("s3 info 1", info_log[ibase], 14);
    check("s3 info 2", info_log[ibase + 1], 14);
    check("s3 depth after 1", depth_at_info[ibase], 3);
    check("s3 depth after 2", depth_at_info[ibase + 1], 2);
    wait_idle("s3", 40);
    tick(2);
    check("s3 ring cleared", bus.rewind_depth, 0);

    // Rewind request on an empty ring only warns.
    ebase = eng_log.size();
    ibase = info_log.size();
    bus.rewind_enable = 1'b1;
    bus.rewind_req    = 1'b1;
    tick();
    bus.rewind_req = 1'b0;
    tick(2);
    check("empty warn count", info_log.size() - ibase, 1);
    check("empty warn code", info_log[ibase], 15);
    check("empty no start", eng_log.size() - ebase, 0);
    check("empty not busy", bus.busy, 0);

    // User ops pending alongside a capture: users first, then the capture.
    ebase = eng_log.size();
    ibase = info_log.size();
    eng_dly = 10;
    bus.ui_slot = 2'd1;
    bus.ui_save = 1'b1;
    tick();
    bus.ui_save = 1'b0;
    tick(4);
    bus.ui_slot = 2'd0;
    bus.ui_load = 1'b1;
    tick();
    bus.ui_load = 1'b0;
    wait_eng("s4", ebase + 3, 120);
    bus.rewind_enable = 1'b0;
    check("s4 op1", eng_log[ebase], 4'h1);
    check("s4 op2", eng_log[ebase + 1], 4'h8);
    check("s4 op3", eng_log[ebase + 2], 4'h4);
    wait_idle("s4", 60);
    check("s4 capture landed", bus.rewind_depth, 1);
    tick();
    check("s4 ring cleared in idle", bus.rewind_depth, 0);
    check("s4 info count", info_log.size() - ibase, 2);
    check("s4 info save", info_log[ibase], 8);
    check("s4 info load", info_log[ibase + 1], 7);

    // Core never acknowledges: watchdog aborts the pause.
    core_dly = 0;
    ebase = eng_log.size();
    bus.ui_slot = 2'd3;
    bus.ui_save = 1'b1;
    tick();
    bus.ui_save = 1'b0;
    tick();
    n = 0;
    k = 0;
    while (bus.core_pause_req === 1'b1 && k < 40) begin
      n++;
      tick();
      k++;
    end
    check("s5 pause cycles", n, 16);
    check("s5 info_req", bus.info_req, 1);
    check("s5 info code", bus.info_code, 13);
    wait_idle("s5", 20);
    check("s5 no start", eng_log.size() - ebase, 0);

    // Simultaneous save+load resolves to a load; engine reports an error.
    core_dly     = 1;
    eng_dly      = 3;
    eng_err_mode = 1'b1;
    ebase = eng_log.size();
    ibase = info_log.size();
    bus.ui_slot = 2'd2;
    bus.ui_save = 1'b1;
    bus.ui_load = 1'b1;
    tick();
    bus.ui_save = 1'b0;
    bus.ui_load = 1'b0;
    wait_info("s6", ibase + 1, 40);
    check("s6 load/slot", eng_log[ebase], 4'hA);
    check("s6 info code", info_log[ibase], 12);
    wait_idle("s6", 20);

    // Reset asserted while waiting on the engine.
    eng_err_mode = 1'b0;
    eng_dly      = 0;
    ebase = eng_log.size();
    bus.ui_slot = 2'd3;
    bus.ui_save = 1'b1;
    tick();
    bus.ui_save = 1'b0;
    wait_eng("s7", ebase + 1, 20);
    tick(2);
    check("s7 in wait busy", bus.busy, 1);
    check("s7 slot before reset", bus.eng_slot, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("s7 async reset outputs", {bus.core_pause_req, bus.eng_start, bus.eng_load, bus.eng_slot,
                                     bus.busy, bus.info_req, bus.info_code, bus.rewind_depth}, 0);
    check("s7 pause_req dropped", bus.core_pause_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
